// File: rtl/mux_8_to_1_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter that drives the selects of
// the 8-to-1 16-bit operand multiplexer.
//   N_REQ          number of requesters
//   IDX_W          width of a requester index / mux select
//   state_e        arbiter state encoding
//   idx_to_onehot  index -> one-hot grant decode
package mux_8_to_1_rr_arbiter_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_8_to_1_rr_arbiter_if.sv
// Request / grant bundle between the requesters and the arbiter.
//   REQ         per-requester request, held high until the requester is done
//   GNT         one-hot grant (zero when idle)
//   S2, S1, S0  binary index of the granted source, wired to the mux selects
//   BUSY        high while any grant is asserted
// master: requester side.  slave: arbiter side.
interface mux_8_to_1_rr_arbiter_if;
  import mux_8_to_1_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] REQ;
  logic [N_REQ-1:0] GNT;
  logic             S2;
  logic             S1;
  logic             S0;
  logic             BUSY;

  modport master (
    output REQ,
    input  GNT, S2, S1, S0, BUSY
  );

  modport slave (
    input  REQ,
    output GNT, S2, S1, S0, BUSY
  );

endinterface

// File: rtl/mux_8_to_1_rr_arbiter_rr_pick_8.sv
// rr_pick_8: combinational rotating find-first.
//   mask_i   candidate requesters
//   ptr_i    index with highest priority; search runs ptr_i, ptr_i+1, ... mod 8
//   found_o  any candidate present
//   idx_o    first candidate in search order (0 when none)
module mux_8_to_1_rr_arbiter_rr_pick_8
  import mux_8_to_1_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] pos;

  // Scan from the far end back toward ptr_i so the last hit is the nearest one.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = ptr_i + IDX_W'(k);
      if (mask_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/mux_8_to_1_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit 8-to-1 mux among eight requesters.
// A contended grant lasts at most MAX_HOLD cycles; an uncontended grant is
// held for as long as the owner keeps its request high.
//   CLK   clock, all state on the rising edge
//   RST   synchronous active-high reset
//   bus   slave side of mux_8_to_1_rr_arbiter_if (REQ in; GNT, S2..S0, BUSY out)
module mux_8_to_1_rr_arbiter
  import mux_8_to_1_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input logic                     CLK,
  input logic                     RST,
  mux_8_to_1_rr_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HcLast = CNT_W'(MAX_HOLD - 1);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] sel_q;
  logic [CNT_W-1:0] hc_q;
  logic [N_REQ-1:0] gnt_q;

  logic [N_REQ-1:0] pick_mask;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             cur_req;
  logic             take;

  // Excluding the current owner makes one search serve both the idle grant
  // (gnt_q is zero) and the handover / forced rotation cases.
  assign pick_mask = bus.REQ & ~gnt_q;
  assign cur_req   = bus.REQ[sel_q];

  // New grant on: idle with a request, owner released, or hold budget spent.
  assign take = pick_found &&
                ((state_q == StIdle) || !cur_req || (hc_q == HcLast));

  mux_8_to_1_rr_arbiter_rr_pick_8 u_pick (
    .mask_i  (pick_mask),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      hc_q    <= '0;
      gnt_q   <= '0;
    end else if (take) begin
      state_q <= StGrant;
      sel_q   <= pick_idx;
      gnt_q   <= idx_to_onehot(pick_idx);
      ptr_q   <= pick_idx + 1'b1;
      hc_q    <= '0;
    end else if (state_q == StGrant && !cur_req) begin
      // Selects keep their last value when going idle.
      state_q <= StIdle;
      gnt_q   <= '0;
    end else if (state_q == StGrant && hc_q != HcLast) begin
      hc_q <= hc_q + 1'b1;
    end
  end

  assign bus.GNT                  = gnt_q;
  assign {bus.S2, bus.S1, bus.S0} = sel_q;
  assign bus.BUSY                 = (state_q == StGrant);

endmodule

// File: tb/tb_mux_8_to_1_rr_arbiter.sv
// Self-checking bench for mux_8_to_1_rr_arbiter: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// behavioural round-robin model.
module tb_mux_8_to_1_rr_arbiter;
  import mux_8_to_1_rr_arbiter_pkg::*;

  localparam int MaxHold = 4;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_8_to_1_rr_arbiter_if bus ();

  mux_8_to_1_rr_arbiter #(
    .MAX_HOLD (MaxHold),
    .CNT_W    (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] in_data [8];
  logic [15:0] y;
  assign y = in_data[{bus.S2, bus.S1, bus.S0}];

  // Behavioural model state
  bit m_active;
  int m_cur;
  int m_ptr;
  int m_hc;

  function automatic int first_from(input logic [7:0] m, input int p);
    for (int k = 0; k < 8; k++) begin
      if (m[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [7:0] q);
    logic [7:0] others;
    int nxt;
    if (r) begin
      m_active = 1'b0;
      m_cur    = 0;
      m_ptr    = 0;
      m_hc     = 0;
    end else if (!m_active) begin
      nxt = first_from(q, m_ptr);
      if (nxt >= 0) begin
        m_active = 1'b1;
        m_cur    = nxt;
        m_ptr    = (nxt + 1) % 8;
        m_hc     = 0;
      end
    end else begin
      others        = q;
      others[m_cur] = 1'b0;
      nxt           = first_from(others, m_ptr);
      if (nxt >= 0 && (!q[m_cur] || m_hc == MaxHold - 1)) begin
        m_cur = nxt;
        m_ptr = (nxt + 1) % 8;
        m_hc  = 0;
      end else if (!q[m_cur]) begin
        m_active = 1'b0;
      end else if (m_hc < MaxHold - 1) begin
        m_hc++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q);
    @(negedge clk);
    rst     = r;
    bus.REQ = q;
    @(posedge clk);
    model_step(r, q);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] gnt, input logic [2:0] sel,
                           input logic busy);
    check({tag, ".gnt"}, 32'(bus.GNT), 32'(gnt));
    check({tag, ".sel"}, 32'({bus.S2, bus.S1, bus.S0}), 32'(sel));
    check({tag, ".busy"}, 32'(bus.BUSY), 32'(busy));
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    eg = m_active ? (8'd1 << m_cur) : 8'd0;
    check_out(tag, eg, 3'(m_cur), m_active);
  endtask

  vec_t       vecs [16];
  logic [7:0] q_hold;
  logic       r_rand;

  initial begin
    bus.REQ = 8'h00;
    for (int i = 0; i < 8; i++) in_data[i] = 16'h00DE + 16'(i) * 16'h0101;

    // rst, req, expected gnt, sel, busy (after the edge)
    vecs[0]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1};
    vecs[3]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
    vecs[5]  = '{1'b0, 8'h80, 8'h80, 3'd7, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 3'd7, 1'b0};
    vecs[7]  = '{1'b0, 8'h81, 8'h01, 3'd0, 1'b1};
    vecs[8]  = '{1'b0, 8'h80, 8'h80, 3'd7, 1'b1};
    vecs[9]  = '{1'b0, 8'h84, 8'h80, 3'd7, 1'b1};
    vecs[10] = '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1};
    vecs[11] = '{1'b0, 8'h44, 8'h04, 3'd2, 1'b1};
    vecs[12] = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1};
    vecs[13] = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1};
    vecs[14] = '{1'b1, 8'h40, 8'h00, 3'd0, 1'b0};
    vecs[15] = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].req);
      check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy);
      if (i == 2) check("vec2.y", 32'(y), 32'h00DE);
    end

    // Fairness: all requesting, each grant held exactly MaxHold cycles.
    step(1'b1, 8'hFF);
    for (int c = 0; c < 8 * MaxHold + MaxHold; c++) begin
      step(1'b0, 8'hFF);
      check_out($sformatf("fair%0d", c), 8'd1 << ((c / MaxHold) % 8),
                3'((c / MaxHold) % 8), 1'b1);
      check($sformatf("fair%0d.y", c), 32'(y), 32'(in_data[(c / MaxHold) % 8]));
    end

    // Uncontended hold, then release: selects stay put.
    step(1'b1, 8'h00);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 8'h20);
      check_out($sformatf("solo%0d", c), 8'h20, 3'd5, 1'b1);
    end
    step(1'b0, 8'h00);
    check_out("solo_rel", 8'h00, 3'd5, 1'b0);

    // A request pulse entirely between edges is not seen.
    @(posedge clk);
    #2 bus.REQ = 8'h02;
    #2 bus.REQ = 8'h00;
    step(1'b0, 8'h00);
    check_out("pulse", 8'h00, 3'd5, 1'b0);

    // Reset in the middle of a contended grant.
    step(1'b1, 8'h00);
    step(1'b0, 8'h08);
    check_out("rmid0", 8'h08, 3'd3, 1'b1);
    step(1'b0, 8'h0C);
    step(1'b0, 8'h0C);
    check_out("rmid_hc2", 8'h08, 3'd3, 1'b1);
    step(1'b1, 8'h0C);
    check_out("rmid_rst", 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h0C);
    check_out("rmid_rel", 8'h04, 3'd2, 1'b1);

    // Randomized run against the model.
    step(1'b1, 8'h00);
    check_model("rnd_rst");
    q_hold = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      q_hold = q_hold ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      r_rand = ($urandom_range(0, 99) == 0);
      step(r_rand, q_hold);
      check_model($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_8_to_1_rr_arbiter.md
# mux_8_to_1_rr_arbiter

Round-robin arbiter that shares the 16-bit 8-to-1 operand multiplexer among eight requesters. It drives the multiplexer selects S2..S0 and returns a one-hot grant, so that exactly one source is routed to Y at a time. A bounded hold counter enforces fairness. The block sits beside multiplexer_8_to_1_16_bit. Requester n's data is wired to In.

## Interface
- MAX_HOLD, 4: maximum consecutive grant cycles while another requester is waiting; legal range 1..15.
- CNT_W, 4: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  8  REQ[n]=1 requests the mux for source In; the requester holds it high until it is done.
- GNT  out  8  one-hot grant, or all-zero when idle; registered.
- S2, S1, S0  out  1 each  binary index of the granted source {S2,S1,S0}; registered; connect to the mux selects.
- BUSY  out  1  registered; equals |GNT.

## Operation
- States:
  - IDLE: GNT=0, BUSY=0.
  - GRANT: exactly one GNT[i]=1, BUSY=1, {S2,S1,S0}=i.
- Pointer PTR (3 bits) names the highest-priority requester. Search order is PTR, PTR+1, … wrapping mod 8.
- IDLE→GRANT: if any REQ bit is high at an edge, grant the first requester in search order.
  - Set PTR=i+1 mod 8.
  - Clear the hold counter HC.
- In GRANT(i), at each edge:
  - REQ[i]=0, other REQ pending: hand over directly to the next requester in search order from PTR, with no idle cycle. Update PTR and clear HC.
  - REQ[i]=0, nothing pending: go to IDLE. GNT goes to 0. S2..S0 hold their last value. PTR is unchanged.
  - REQ[i]=1 and HC=MAX_HOLD-1 and another REQ pending: forced rotation to the next requester, exactly as on release. Requester i loses the grant and re-arbitrates normally.
  - Otherwise: keep the grant. HC increments and saturates at MAX_HOLD-1.
- With no competition, a grant is held indefinitely while REQ[i]=1.
- REQ bits are sampled only at edges. A pulse between edges is ignored.
- GNT is always one-hot or zero. {S2,S1,S0} always matches the asserted GNT bit.

## Timing
- Reset values: GNT=8'h00, S2=S1=S0=0, BUSY=0, PTR=0, HC=0, state IDLE.
- Request latency: REQ[n] high before edge k → GNT[n]=1 and selects valid immediately after edge k (1 cycle).
- Release latency: REQ[i] low before edge k → GNT[i]=0 after edge k. Any successor grant appears after that same edge.
- Contended grant length: exactly MAX_HOLD cycles. Uncontended: unbounded.
- RST high at an edge mid-grant: the grant drops after that edge and PTR returns to 0. Pending requests are re-arbitrated at the first edge with RST low.
- Mux output Y is valid in the same cycle GNT is visible, since the mux path is combinational.

## Structure
- Shared package holds:
  - constants N_REQ=8, IDX_W=3
  - state encoding IDLE=1'b0, GRANT=1'b1
- Sub-module rr_pick_8: combinational rotate-from-PTR find-first. Inputs: 8-bit mask and 3-bit PTR. Outputs: found flag and 3-bit index. It is used both for the IDLE→GRANT decision and for handover.
- Top level: state register, PTR, HC, output registers, and index-to-one-hot decode for GNT.

## Test plan
- Reset: REQ=8'hFF with RST=1 → GNT=00, S=000, BUSY=0 throughout. After RST drops, GNT=01 after the first edge, and Y=I0 data (16'h00DE with I0 loaded as 16'h00DE).
- Fairness, MAX_HOLD=4, REQ=8'hFF held: grants rotate 01,02,04,…,80,01. Each is held exactly 4 cycles. S2..S0 step 0..7 and Y tracks I0..I7.
- Uncontended hold: only REQ[5]=1 for 20 cycles → GNT=20, S=101 for all 20 cycles. Drop REQ[5] → GNT=00 next edge, S stays 101, BUSY=0.
- Zero-bubble handover: REQ[2] granted, REQ[6] raised. REQ[2] dropped before edge k → GNT goes 04→40 across edge k, with BUSY continuously 1.
- Wrap priority: after a grant to 7 (PTR=0), REQ=8'h81 → GNT=01 first, not 80.
- Reset mid-grant: GNT=08 at HC=2 and RST pulsed for one cycle → GNT=00, PTR=0. With REQ=8'h0C still high, GNT=04 one edge after RST releases.
